// File: rtl/wb_buffer.sv
// Writeback buffer: an in-order FIFO between the EXU writeback bus and the register file,
// with combinational forwarding of pending results to the decode-stage source lookups.
module wb_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] wb_instr_tag,
   input  logic [31:0]     wb_instr,
   output logic            rf_wr_en,
   output logic [4:0]      rf_wr_addr,
   output logic [XLEN-1:0] rf_wr_data,
   input  logic            rf_wr_ready,
   output logic [XLEN-1:0] instr_tag_out,
   output logic [31:0]     instr_out,
   input  logic [4:0]      fwd_rs1_addr,
   input  logic [4:0]      fwd_rs2_addr,
   output logic            fwd_rs1_hit,
   output logic [XLEN-1:0] fwd_rs1_data,
   output logic            fwd_rs2_hit,
   output logic [XLEN-1:0] fwd_rs2_data,
   output logic            wbb_stall,
   output logic            wbb_empty,
   output logic            wbb_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]      rd_mem_q    [DEPTH];
   logic [XLEN-1:0] data_mem_q  [DEPTH];
   logic [XLEN-1:0] tag_mem_q   [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic enq_req, enq, deq, full;

   assign enq_req = wb_valid && (wb_rd_addr != 5'd0);
   assign full    = (count_q == CW'(DEPTH));
   assign deq     = rf_wr_en && rf_wr_ready;
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign enq     = enq_req && (!full || deq);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (enq && !deq) count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
      if (enq_req && full && !deq) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Payload storage carries no reset; only slots below count are ever observed.
   always_ff @(posedge clk) begin
      if (!rst && enq) begin
         rd_mem_q[wr_ptr_q]    <= wb_rd_addr;
         data_mem_q[wr_ptr_q]  <= wb_data;
         tag_mem_q[wr_ptr_q]   <= wb_instr_tag;
         instr_mem_q[wr_ptr_q] <= wb_instr;
      end
   end

   assign rf_wr_en      = (count_q != '0);
   assign rf_wr_addr    = rf_wr_en ? rd_mem_q[rd_ptr_q]    : 5'd0;
   assign rf_wr_data    = rf_wr_en ? data_mem_q[rd_ptr_q]  : '0;
   assign instr_tag_out = rf_wr_en ? tag_mem_q[rd_ptr_q]   : '0;
   assign instr_out     = rf_wr_en ? instr_mem_q[rd_ptr_q] : 32'd0;

   assign wbb_stall    = (count_q >= CW'(DEPTH - 1));
   assign wbb_empty    = (count_q == '0);
   assign wbb_overflow = ovf_q;

   logic [PW-1:0] idx;

   // Scan oldest to youngest so the youngest match wins; the incoming bus overrides all.
   always_comb begin
      idx          = '0;
      fwd_rs1_hit  = 1'b0;
      fwd_rs1_data = '0;
      fwd_rs2_hit  = 1'b0;
      fwd_rs2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (rd_mem_q[idx] == fwd_rs1_addr) begin
               fwd_rs1_hit  = 1'b1;
               fwd_rs1_data = data_mem_q[idx];
            end
            if (rd_mem_q[idx] == fwd_rs2_addr) begin
               fwd_rs2_hit  = 1'b1;
               fwd_rs2_data = data_mem_q[idx];
            end
         end
      end
      if (enq_req && (wb_rd_addr == fwd_rs1_addr)) begin
         fwd_rs1_hit  = 1'b1;
         fwd_rs1_data = wb_data;
      end
      if (enq_req && (wb_rd_addr == fwd_rs2_addr)) begin
         fwd_rs2_hit  = 1'b1;
         fwd_rs2_data = wb_data;
      end
      if (fwd_rs1_addr == 5'd0) begin
         fwd_rs1_hit  = 1'b0;
         fwd_rs1_data = '0;
      end
      if (fwd_rs2_addr == 5'd0) begin
         fwd_rs2_hit  = 1'b0;
         fwd_rs2_data = '0;
      end
   end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of 2, 2..16).
REQ-002 SHALL have parameter XLEN, default global XLEN (32), datapath width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wb_valid/wb_rd_addr/wb_data  input  1/5/XLEN  EXU writeback bus: valid, destination register, result.
REQ-006 SHALL have ports wb_instr_tag/wb_instr  input  XLEN/32  debug tag and instruction word of the writeback.
REQ-007 SHALL have ports rf_wr_en/rf_wr_addr/rf_wr_data  output  1/5/XLEN  register-file write port (head entry).
REQ-008 SHALL have port rf_wr_ready  input  1  register file accepts the write this cycle.
REQ-009 SHALL have ports instr_tag_out/instr_out  output  XLEN/32  debug tag and instruction of the head entry.
REQ-010 SHALL have ports fwd_rs1_addr/fwd_rs2_addr  input  5  IDU1 source-register lookup addresses.
REQ-011 SHALL have ports fwd_rs1_hit/fwd_rs1_data, fwd_rs2_hit/fwd_rs2_data  output  1/XLEN  forwarding result per source.
REQ-012 SHALL have ports wbb_stall/wbb_empty/wbb_overflow  output  1/1/1  almost-full, empty, sticky overflow error.

Function
REQ-013 SHALL store entries {rd_addr, data, instr_tag, instr} in a circular FIFO with read/write pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-014 SHALL enqueue when wb_valid=1 and wb_rd_addr!=0; wb_valid with rd 0 is discarded, no state change.
REQ-015 SHALL drive rf_wr_en=1 whenever count>0, with rf_wr_addr/rf_wr_data/instr_tag_out/instr_out from head entry; all zero when empty.
REQ-016 SHALL dequeue (advance read pointer) on a rising edge where rf_wr_en=1 and rf_wr_ready=1; head held stable otherwise.
REQ-017 SHALL have enqueue-to-rf_wr_en latency of exactly 1 cycle when empty (entry written at edge N, visible after edge N).
REQ-018 SHALL, on simultaneous enqueue and dequeue, keep count unchanged, including when count=DEPTH (enqueue accepted).
REQ-019 SHALL, on enqueue with count=DEPTH and no dequeue, drop the incoming write and set wbb_overflow=1, held until reset.
REQ-020 SHALL assert wbb_stall=1 combinationally when count>=DEPTH-1; wbb_empty=1 when count=0.
REQ-021 SHALL compute fwd_rsN_hit/data combinationally: incoming wb (valid, rd!=0, rd==addr) has highest priority, then youngest matching valid entry, down to head.
REQ-022 SHALL treat the head entry being dequeued in the current cycle as still valid for forwarding.
REQ-023 SHALL return hit=0, data=0 when fwd_rsN_addr=0 or no match.
REQ-024 SHALL preserve program order: rf writes leave in exactly enqueue order; two entries to same rd both written.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, clear pointers, count and wbb_overflow; entry payloads need not be cleared.
REQ-026 SHALL drive after reset: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, instr_tag_out=0, instr_out=0, fwd hits 0, wbb_empty=1, wbb_stall=0, wbb_overflow=0.
REQ-027 SHALL, on reset mid-operation, discard all pending entries and ignore wb_valid in the reset cycle.

Verification
REQ-028 SHALL cover: rf_wr_ready=1, wb x5=0x11 at cycle 0 -> rf_wr_en=1, addr 5, data 0x11 cycle 1; empty cycle 2.
REQ-029 SHALL cover: rf_wr_ready=0, wb x1..x4 (DEPTH=4) -> wbb_stall=1 after 3rd, count 4; 5th wb x6 -> wbb_overflow=1, x6 never written.
REQ-030 SHALL cover: buffer holds x7=0xA then x7=0xB, fwd_rs1_addr=7 -> hit=1 data 0xB; same-cycle wb x7=0xC -> data 0xC.
REQ-031 SHALL cover: full, rf_wr_ready=1 and wb x9 same cycle -> count stays 4, x9 written last after prior three.
REQ-032 SHALL cover: wb_valid with rd 0, data 0xFFFF -> no enqueue, wbb_empty stays 1; fwd addr 0 -> hit 0.
REQ-033 SHALL cover: rst=1 with 3 pending and wbb_overflow=1 -> next cycle rf_wr_en=0, wbb_empty=1, wbb_overflow=0.
